// File: rtl/logo_pkg.sv
// Shared definitions for the logo scroll controller and the logo painters:
// coordinate width, default bounds and the scroll state encoding.
package logo_pkg;

  localparam int LOGO_W = 11;

  localparam logic [LOGO_W-1:0] DELT_MIN_DEF     = 11'd0;
  localparam logic [LOGO_W-1:0] DELT_MAX_DEF     = 11'd200;
  localparam logic [LOGO_W-1:0] STEP_DEF         = 11'd4;
  localparam logic [7:0]        FRAME_DIV_DEF    = 8'd2;
  localparam logic [7:0]        DWELL_FRAMES_DEF = 8'd3;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RIGHT   = 3'd1,
    DWELL_R = 3'd2,
    LEFT    = 3'd3,
    DWELL_L = 3'd4
  } scroll_state_e;

endpackage

// File: rtl/frame_tick_gen.sv
// Registers the active-low vertical sync and flags its falling edge,
// giving exactly one tick per frame.
module frame_tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic vs,
  output logic tick
);

  logic vs_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vs_q <= 1'b1;
    else      vs_q <= vs;
  end

  assign tick = vs_q & ~vs;

endmodule

// File: rtl/logo_scroll_ctrl.sv
// Bouncing horizontal offset for the logo painters: steps every FRAME_DIV
// frames, dwells DWELL_FRAMES frames at each bound, then reverses.
module logo_scroll_ctrl
  import logo_pkg::*;
#(
  parameter logic [LOGO_W-1:0] DELT_MIN     = DELT_MIN_DEF,
  parameter logic [LOGO_W-1:0] DELT_MAX     = DELT_MAX_DEF,
  parameter logic [LOGO_W-1:0] STEP         = STEP_DEF,
  parameter logic [7:0]        FRAME_DIV    = FRAME_DIV_DEF,
  parameter logic [7:0]        DWELL_FRAMES = DWELL_FRAMES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vs,
  input  logic              enable,
  input  logic              home,
  output logic [LOGO_W-1:0] delt,
  output logic              dir,
  output logic              step_pulse
);

  localparam logic [7:0] FRAME_LAST = FRAME_DIV - 8'd1;
  localparam logic [7:0] DWELL_LAST = DWELL_FRAMES - 8'd1;

  scroll_state_e     state, state_d;
  logic [LOGO_W-1:0] delt_d;
  logic              dir_d;
  logic [7:0]        frame_cnt, frame_cnt_d;
  logic [7:0]        dwell_cnt, dwell_cnt_d;
  logic              stepped, stepped_d;
  logic              step_pulse_d;
  logic              tick;
  logic [LOGO_W:0]   sum_right;
  logic [LOGO_W:0]   left_floor;
  logic              at_bound;

  frame_tick_gen u_tick (
    .clk  (clk),
    .rst  (rst),
    .vs   (vs),
    .tick (tick)
  );

  // One guard bit so delt + STEP can be compared against the bound unwrapped.
  assign sum_right  = {1'b0, delt} + {1'b0, STEP};
  assign left_floor = {1'b0, DELT_MIN} + {1'b0, STEP};
  assign at_bound   = dir ? (delt == DELT_MIN) : (delt == DELT_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      delt       <= DELT_MIN;
      dir        <= 1'b0;
      frame_cnt  <= '0;
      dwell_cnt  <= '0;
      stepped    <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      state      <= state_d;
      delt       <= delt_d;
      dir        <= dir_d;
      frame_cnt  <= frame_cnt_d;
      dwell_cnt  <= dwell_cnt_d;
      stepped    <= stepped_d;
      step_pulse <= step_pulse_d;
    end
  end

  // NOTE: every output of this block is defaulted first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state;
    delt_d       = delt;
    dir_d        = dir;
    frame_cnt_d  = frame_cnt;
    dwell_cnt_d  = dwell_cnt;
    stepped_d    = 1'b0;
    step_pulse_d = stepped;

    if (home) begin
      state_d      = enable ? RIGHT : IDLE;
      delt_d       = DELT_MIN;
      dir_d        = 1'b0;
      frame_cnt_d  = '0;
      dwell_cnt_d  = '0;
      step_pulse_d = 1'b0;
    end else if (state != IDLE && !enable) begin
      // Freezing abandons any dwell; dir still holds the pre-dwell direction.
      state_d     = IDLE;
      frame_cnt_d = '0;
      dwell_cnt_d = '0;
    end else begin
      unique case (state)
        IDLE: begin
          frame_cnt_d = '0;
          dwell_cnt_d = '0;
          if (enable) begin
            if (dir) state_d = at_bound ? DWELL_L : LEFT;
            else     state_d = at_bound ? DWELL_R : RIGHT;
          end
        end
        RIGHT, LEFT: begin
          if (tick) begin
            if (frame_cnt == FRAME_LAST) begin
              frame_cnt_d = '0;
              stepped_d   = 1'b1;
              if (state == RIGHT) begin
                if (sum_right >= {1'b0, DELT_MAX}) begin
                  delt_d  = DELT_MAX;
                  state_d = DWELL_R;
                end else begin
                  delt_d = sum_right[LOGO_W-1:0];
                end
              end else begin
                if ({1'b0, delt} <= left_floor) begin
                  delt_d  = DELT_MIN;
                  state_d = DWELL_L;
                end else begin
                  delt_d = delt - STEP;
                end
              end
            end else begin
              frame_cnt_d = frame_cnt + 8'd1;
            end
          end
        end
        DWELL_R, DWELL_L: begin
          if (tick) begin
            if (dwell_cnt == DWELL_LAST) begin
              dwell_cnt_d = '0;
              frame_cnt_d = '0;
              dir_d       = ~dir;
              state_d     = (state == DWELL_R) ? LEFT : RIGHT;
            end else begin
              dwell_cnt_d = dwell_cnt + 8'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule
